// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider controller, one quotient bit per clock.
// Optional signed support is enabled by defining DIV_SIGNED_EN.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             write_quotient,
  output logic             write_remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] q, r, d, a_mag, b_mag, q_fix, r_fix;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] shifted, trial;
  logic dz;
  assign shifted = {r, q[WIDTH-1]};
  assign trial = shifted - {1'b0, d};
  assign busy = state != IDLE;
  assign stall = (start & (state == IDLE)) | busy;
  assign write_quotient = done;
  assign write_remainder = done;
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r, sa, sb;
  assign sa = is_signed & dividend[WIDTH-1];
  assign sb = is_signed & divisor[WIDTH-1];
  assign a_mag = sa ? -dividend : dividend;
  assign b_mag = sb ? -divisor : divisor;
  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -r : r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (!flush && state == IDLE && start) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
`else
  logic unused_signed;
  assign unused_signed = is_signed;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = q;
  assign r_fix = r;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = start ? ((divisor == '0) ? FIN : RUN) : IDLE;
    else if (state == RUN) state_nx = (cnt == CNT_W'(1)) ? FIN : RUN;
    else state_nx = IDLE;
  end
  // On divide-by-zero q holds the raw dividend so it can be returned as the remainder.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      dz <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (!flush) begin
        if (state == IDLE && start) begin
          q <= (divisor == '0) ? dividend : a_mag;
          d <= b_mag;
          r <= '0;
          cnt <= CNT_W'(WIDTH);
          dz <= divisor == '0;
        end else if (state == RUN) begin
          r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - CNT_W'(1);
        end else if (state == FIN) begin
          quotient <= dz ? '1 : q_fix;
          remainder <= dz ? q : r_fix;
          done <= 1'b1;
          div_by_zero <= dz;
        end
      end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of div_sequencer latency, results, flush, reset and back-to-back issue.
module tb_div_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0, flush = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, stall, done, write_quotient, write_remainder, div_by_zero;
  logic [31:0] quotient, remainder;
  int n_checks = 0, n_fail = 0, e;
  logic stall_bad, seen_done;
  div_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .stall(stall), .done(done),
    .write_quotient(write_quotient), .write_remainder(write_remainder),
    .div_by_zero(div_by_zero), .quotient(quotient), .remainder(remainder)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
    @(negedge clk);
    dividend = a;
    divisor = b;
    is_signed = sg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int e0, output int en);
    en = e0;
    stall_bad = 1'b0;
    while (!done && en < 200) begin
      if (!stall) stall_bad = 1'b1;
      @(negedge clk);
      en++;
    end
  endtask
  task automatic check_op(input string tag, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int elat);
    chk({tag, " latency"}, 32'(e), 32'(elat));
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, edz});
    chk({tag, " strobes"}, {29'b0, done, write_quotient, write_remainder}, 32'h7);
    chk({tag, " stall held"}, {31'b0, stall_bad}, 32'h0);
    @(negedge clk);
    chk({tag, " strobes drop"}, {29'b0, done, write_quotient, write_remainder}, 32'h0);
    chk({tag, " dbz drop"}, {31'b0, div_by_zero}, 32'h0);
    chk({tag, " q held"}, quotient, eq);
  endtask
  task automatic no_done(input string tag, input int cycles);
    seen_done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk(tag, {31'b0, seen_done}, 32'h0);
  endtask
  initial begin
    #7;
    chk("reset busy/stall/done", {28'b0, busy, stall, done, div_by_zero}, 32'h0);
    chk("reset quotient", quotient, 32'h0);
    chk("reset remainder", remainder, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd100, 32'd7, 1'b0);
    chk("busy after issue", {31'b0, busy}, 32'h1);
    wait_done(1, e);
    check_op("100/7", 32'd14, 32'd2, 1'b0, 34);
    issue(32'h1234, 32'h0, 1'b0);
    wait_done(1, e);
    check_op("dbz", 32'hFFFFFFFF, 32'h1234, 1'b1, 2);
    issue(32'd5, 32'd9, 1'b0);
    wait_done(1, e);
    check_op("5/9", 32'd0, 32'd5, 1'b0, 34);
    issue(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_done(1, e);
    check_op("max/1", 32'hFFFFFFFF, 32'd0, 1'b0, 34);
`ifdef DIV_SIGNED_EN
    issue(32'hFFFFFF9C, 32'd7, 1'b1);
    wait_done(1, e);
    check_op("-100/7", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
    issue(32'd100, 32'hFFFFFFF9, 1'b1);
    wait_done(1, e);
    check_op("100/-7", 32'hFFFFFFF2, 32'd2, 1'b0, 34);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(1, e);
    check_op("minneg/-1", 32'h80000000, 32'd0, 1'b0, 34);
`else
    issue(32'hFFFFFF9C, 32'd7, 1'b1);
    wait_done(1, e);
    check_op("signed ignored", 32'h24924916, 32'd2, 1'b0, 34);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(1, e);
    check_op("unsigned big/max", 32'd0, 32'h80000000, 1'b0, 34);
`endif
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, e);
    check_op("start while busy", 32'd14, 32'd2, 1'b0, 34);
    no_done("no second done", 40);
    issue(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'h0);
    no_done("flush no done", 40);
    chk("flush q kept", quotient, 32'd14);
    chk("flush r kept", remainder, 32'd2);
    @(negedge clk);
    dividend = 32'd77;
    divisor = 32'd7;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush beats start", {31'b0, busy}, 32'h0);
    no_done("flush+start no done", 40);
    issue(32'hFFFFFFFF, 32'h10, 1'b0);
    wait_done(1, e);
    check_op("max/16", 32'h0FFFFFFF, 32'hF, 1'b0, 34);
    issue(32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst flags", {26'b0, busy, stall, done, write_quotient, write_remainder, div_by_zero}, 32'h0);
    chk("async rst quotient", quotient, 32'h0);
    chk("async rst remainder", remainder, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd9, 32'd3, 1'b0);
    wait_done(1, e);
    chk("b2b first q", quotient, 32'd3);
    chk("b2b first r", remainder, 32'd0);
    dividend = 32'd10;
    divisor = 32'd4;
    start = 1'b1;
    #1;
    chk("b2b stall on done", {31'b0, stall}, 32'h1);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, e);
    check_op("b2b second", 32'd2, 32'd2, 1'b0, 34);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
